risc_spm_ctrl: RTL and testbench
================================

// Module: risc_spm_ctrl
// PURPOSE
//  Control unit FSM for the RISC SPM processor datapath (risc_spm_if bus).
//  Sequences fetch/decode/execute of 8-bit instructions: drives register load
//  strobes, PC control, Bus_1/Bus_2 mux selects and the memory write strobe.
//  Also keeps a retired-instruction counter for testbench coverage/scoreboard.
// PARAMETERS
//  CNT_W   16  width of retired-instruction counter (saturates, no wrap)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      async reset, active-low
//  instruction   in   8      IR contents: [7:4] opcode, [3:2] src, [1:0] dest
//  zero          in   1      registered zero flag from Reg_Z
//  load_r        out  4      one-hot load strobe for R0..R3
//  load_pc       out  1      load PC from Bus_2
//  inc_pc        out  1      increment PC
//  sel_bus1      out  3      0..3=R0..R3, 4=PC, others unused
//  sel_bus2      out  2      0=ALU, 1=Bus_1, 2=memory word
//  load_ir       out  1      load IR from Bus_2
//  load_add_r    out  1      load memory address register from Bus_2
//  load_reg_y    out  1      load ALU operand Reg_Y from Bus_2
//  load_reg_z    out  1      load zero flag Reg_Z from ALU
//  write         out  1      memory write strobe (data = Bus_1)
//  halted        out  1      FSM in S_HALT
//  instr_cnt     out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT, 5 RD, 6 WR, 7 BR, 8 BRZ;
//    9..15 illegal -> S_HALT. State reg async-cleared to S_IDLE on rst low.
//  - Outputs decoded combinationally from registered state + instruction/zero;
//    any strobe not listed for a state is 0. In reset/S_IDLE/S_HALT all 0.
//  - S_IDLE -> S_FET1 unconditionally (first cycle after rst release).
//  - S_FET1: sel_bus1=PC, sel_bus2=Bus_1, load_add_r -> S_FET2.
//  - S_FET2: sel_bus2=MEM, load_ir, inc_pc -> S_DEC.
//  - S_DEC by opcode:
//     NOP: -> S_FET1 (retire).
//     ADD/SUB/AND: sel_bus1=src, sel_bus2=Bus_1, load_reg_y -> S_EX1.
//     NOT: sel_bus1=src, sel_bus2=ALU, load_reg_z, load_r[dest] -> S_FET1 (retire).
//     RD/WR/BR: sel_bus1=PC, sel_bus2=Bus_1, load_add_r -> S_RD1/S_WR1/S_BR1.
//     BRZ: zero=1 as BR -> S_BR1; zero=0 inc_pc (skip operand) -> S_FET1 (retire).
//     illegal: -> S_HALT, no strobes.
//  - S_EX1: sel_bus1=dest, sel_bus2=ALU, load_reg_z, load_r[dest] -> S_FET1 (retire).
//  - S_RD1: sel_bus2=MEM, load_add_r, inc_pc -> S_RD2.
//  - S_RD2: sel_bus2=MEM, load_r[dest] -> S_FET1 (retire).
//  - S_WR1: sel_bus2=MEM, load_add_r, inc_pc -> S_WR2.
//  - S_WR2: sel_bus1=src, write -> S_FET1 (retire).
//  - S_BR1: sel_bus2=MEM, load_add_r -> S_BR2.
//  - S_BR2: sel_bus2=MEM, load_pc -> S_FET1 (retire).
//  - S_HALT: absorbing; halted=1; leaves only via rst.
//  - Cycle counts: NOP 3, NOT 3, BRZ-not-taken 3, ALU 4, RD/WR/BR/BRZ-taken 5.
//  - instr_cnt: +1 on the clock edge leaving a retiring state; 0 on reset;
//    holds at all-ones; never counts the halting instruction.
//  - load_r always one-hot or zero; at most one of load_pc/inc_pc per cycle.
//  - rst asserted mid-instruction: all strobes drop immediately, counter 0,
//    restart at S_IDLE; no partial write.
// TESTING
//  - Reset: rst low 2 cycles mid-S_WR2 -> write=0 at once, instr_cnt=0, fetch
//    starts 2 cycles after release (S_IDLE, S_FET1).
//  - ADD R1,R2 (8'h16): S_DEC sel_bus1=1 load_reg_y; S_EX1 sel_bus1=2, sel_bus2=0,
//    load_r=4'b0100, load_reg_z; instr_cnt +1 after 4 cycles.
//  - RD R3 (8'h53) then WR from R3 (8'h6C): load_r=4'b1000 in S_RD2; write=1 with
//    sel_bus1=3 in S_WR2; inc_pc pulses 2 per instruction.
//  - BRZ 8'h80: zero=0 -> inc_pc in S_DEC, back to S_FET1; zero=1 -> load_pc in
//    S_BR2 after 5 cycles total.
//  - Illegal 8'hF0 in S_DEC -> halted=1 next cycle, all strobes 0 for 20 cycles,
//    instr_cnt frozen.
//  - CNT_W=4: run 20 NOPs -> instr_cnt saturates at 15.

Source files
------------

// File: rtl/risc_spm_ctrl_if.sv
// Control bus between the RISC SPM control unit and its datapath.
// master = control unit (drives strobes/selects), slave = datapath.
interface risc_spm_if #(
   parameter int CNT_W = 16
);
   logic [7:0]       instruction;  // IR contents: [7:4] opcode, [3:2] src, [1:0] dest
   logic             zero;         // registered zero flag from Reg_Z
   logic [3:0]       load_r;       // one-hot load strobe for R0..R3
   logic             load_pc;
   logic             inc_pc;
   logic [2:0]       sel_bus1;     // 0..3 = R0..R3, 4 = PC
   logic [1:0]       sel_bus2;     // 0 = ALU, 1 = Bus_1, 2 = memory word
   logic             load_ir;
   logic             load_add_r;
   logic             load_reg_y;
   logic             load_reg_z;
   logic             write;
   logic             halted;
   logic [CNT_W-1:0] instr_cnt;
   logic [3:0]       state_dbg;    // raw FSM state, for checkers

   modport master (
      input  instruction, zero,
      output load_r, load_pc, inc_pc, sel_bus1, sel_bus2, load_ir, load_add_r,
             load_reg_y, load_reg_z, write, halted, instr_cnt, state_dbg
   );

   modport slave (
      output instruction, zero,
      input  load_r, load_pc, inc_pc, sel_bus1, sel_bus2, load_ir, load_add_r,
             load_reg_y, load_reg_z, write, halted, instr_cnt, state_dbg
   );
endinterface

// File: rtl/risc_spm_ctrl.sv
// RISC SPM control unit: fetch/decode/execute sequencer for 8-bit
// instructions plus a saturating retired-instruction counter.
// There is no valid/ready handshake here: every strobe is a single-cycle
// command to the datapath, decoded from the registered state (and, in
// S_DEC, from the instruction and zero flag), and is consumed on the next
// rising clock edge unconditionally.
module risc_spm_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic      clk,
   input  logic      rst,      // asynchronous, active-low
   risc_spm_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FET1 = 4'd1,
      S_FET2 = 4'd2,
      S_DEC  = 4'd3,
      S_EX1  = 4'd4,
      S_RD1  = 4'd5,
      S_RD2  = 4'd6,
      S_WR1  = 4'd7,
      S_WR2  = 4'd8,
      S_BR1  = 4'd9,
      S_BR2  = 4'd10,
      S_HALT = 4'd11
   } state_t;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_RD  = 4'd5;
   localparam logic [3:0] OP_WR  = 4'd6;
   localparam logic [3:0] OP_BR  = 4'd7;
   localparam logic [3:0] OP_BRZ = 4'd8;

   localparam logic [2:0] SEL1_PC   = 3'd4;
   localparam logic [1:0] SEL2_ALU  = 2'd0;
   localparam logic [1:0] SEL2_BUS1 = 2'd1;
   localparam logic [1:0] SEL2_MEM  = 2'd2;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   logic [3:0] opcode;
   logic [1:0] src;
   logic [1:0] dest;
   logic [3:0] dest_oh;

   logic [3:0] load_r;
   logic       load_pc, inc_pc, load_ir, load_add_r;
   logic       load_reg_y, load_reg_z, write, halted;
   logic [2:0] sel_bus1;
   logic [1:0] sel_bus2;

   assign opcode  = bus.instruction[7:4];
   assign src     = bus.instruction[3:2];
   assign dest    = bus.instruction[1:0];
   assign dest_oh = 4'b0001 << dest;

   // State register; reset forces S_IDLE so every strobe drops at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and strobe decode; retire marks the last cycle of an instruction.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      load_r     = 4'b0000;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      sel_bus1   = 3'd0;
      sel_bus2   = SEL2_ALU;
      load_ir    = 1'b0;
      load_add_r = 1'b0;
      load_reg_y = 1'b0;
      load_reg_z = 1'b0;
      write      = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FET1;
         S_FET1: begin
            sel_bus1   = SEL1_PC;
            sel_bus2   = SEL2_BUS1;
            load_add_r = 1'b1;
            state_d    = S_FET2;
         end
         S_FET2: begin
            sel_bus2 = SEL2_MEM;
            load_ir  = 1'b1;
            inc_pc   = 1'b1;
            state_d  = S_DEC;
         end
         S_DEC: begin
            case (opcode)
               OP_NOP: begin
                  retire  = 1'b1;
                  state_d = S_FET1;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  sel_bus1   = {1'b0, src};
                  sel_bus2   = SEL2_BUS1;
                  load_reg_y = 1'b1;
                  state_d    = S_EX1;
               end
               OP_NOT: begin
                  sel_bus1   = {1'b0, src};
                  sel_bus2   = SEL2_ALU;
                  load_reg_z = 1'b1;
                  load_r     = dest_oh;
                  retire     = 1'b1;
                  state_d    = S_FET1;
               end
               OP_RD, OP_WR, OP_BR: begin
                  // Operand word follows the opcode: point the address register at it.
                  sel_bus1   = SEL1_PC;
                  sel_bus2   = SEL2_BUS1;
                  load_add_r = 1'b1;
                  if (opcode == OP_RD)      state_d = S_RD1;
                  else if (opcode == OP_WR) state_d = S_WR1;
                  else                      state_d = S_BR1;
               end
               OP_BRZ: begin
                  if (bus.zero) begin
                     sel_bus1   = SEL1_PC;
                     sel_bus2   = SEL2_BUS1;
                     load_add_r = 1'b1;
                     state_d    = S_BR1;
                  end else begin
                     // Not taken: step the PC over the unused target word.
                     inc_pc  = 1'b1;
                     retire  = 1'b1;
                     state_d = S_FET1;
                  end
               end
               default: state_d = S_HALT;
            endcase
         end
         S_EX1: begin
            sel_bus1   = {1'b0, dest};
            sel_bus2   = SEL2_ALU;
            load_reg_z = 1'b1;
            load_r     = dest_oh;
            retire     = 1'b1;
            state_d    = S_FET1;
         end
         S_RD1, S_WR1: begin
            sel_bus2   = SEL2_MEM;
            load_add_r = 1'b1;
            inc_pc     = 1'b1;
            state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
         end
         S_RD2: begin
            sel_bus2 = SEL2_MEM;
            load_r   = dest_oh;
            retire   = 1'b1;
            state_d  = S_FET1;
         end
         S_WR2: begin
            sel_bus1 = {1'b0, src};
            write    = 1'b1;
            retire   = 1'b1;
            state_d  = S_FET1;
         end
         S_BR1: begin
            sel_bus2   = SEL2_MEM;
            load_add_r = 1'b1;
            state_d    = S_BR2;
         end
         S_BR2: begin
            sel_bus2 = SEL2_MEM;
            load_pc  = 1'b1;
            retire   = 1'b1;
            state_d  = S_FET1;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   // Retired-instruction count; sticks at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign bus.load_r     = load_r;
   assign bus.load_pc    = load_pc;
   assign bus.inc_pc     = inc_pc;
   assign bus.sel_bus1   = sel_bus1;
   assign bus.sel_bus2   = sel_bus2;
   assign bus.load_ir    = load_ir;
   assign bus.load_add_r = load_add_r;
   assign bus.load_reg_y = load_reg_y;
   assign bus.load_reg_z = load_reg_z;
   assign bus.write      = write;
   assign bus.halted     = halted;
   assign bus.instr_cnt  = cnt_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_risc_spm_ctrl.sv
// Directed bench for risc_spm_ctrl: reset, each instruction class,
// mid-instruction reset, halt on illegal opcode, counter saturation.
module tb_risc_spm_ctrl;

   localparam logic [7:0] F_LPC = 8'h80;
   localparam logic [7:0] F_IPC = 8'h40;
   localparam logic [7:0] F_LIR = 8'h20;
   localparam logic [7:0] F_LAR = 8'h10;
   localparam logic [7:0] F_LY  = 8'h08;
   localparam logic [7:0] F_LZ  = 8'h04;
   localparam logic [7:0] F_WR  = 8'h02;
   localparam logic [7:0] F_H   = 8'h01;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt = 0;

   risc_spm_if #(.CNT_W(16)) bus  ();
   risc_spm_if #(.CNT_W(4))  bus4 ();

   risc_spm_ctrl #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
   risc_spm_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] stb(input logic [3:0] lr, input logic [7:0] f);
      return {20'd0, lr, f};
   endfunction

   function automatic logic [31:0] obs();
      return {20'd0, bus.load_r, bus.load_pc, bus.inc_pc, bus.load_ir, bus.load_add_r,
              bus.load_reg_y, bus.load_reg_z, bus.write, bus.halted};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Check strobes, and selects where s1/s2 are non-negative.
   task automatic chk_out(input string tag, input logic [3:0] lr, input logic [7:0] f,
                          input int s1, input int s2);
      check({tag, "_stb"}, obs(), stb(lr, f));
      if (s1 >= 0) check({tag, "_sel1"}, 32'(bus.sel_bus1), 32'(s1));
      if (s2 >= 0) check({tag, "_sel2"}, 32'(bus.sel_bus2), 32'(s2));
   endtask

   task automatic chk_cnt(input string tag);
      check({tag, "_cnt"}, 32'(bus.instr_cnt), 32'(exp_cnt));
   endtask

   // Starts at the negedge in S_FET1, ends at the negedge in S_DEC.
   task automatic do_fetch(input string tag, input logic [7:0] ins);
      chk_out({tag, "_fet1"}, 4'b0000, F_LAR, 4, 1);
      bus.instruction = ins;
      step();
      chk_out({tag, "_fet2"}, 4'b0000, F_LIR | F_IPC, -1, 2);
      step();
   endtask

   initial begin
      rst = 1'b0;
      bus.instruction  = 8'h00;
      bus.zero         = 1'b0;
      bus4.instruction = 8'h00;
      bus4.zero        = 1'b0;
      step();
      step();
      chk_out("reset", 4'b0000, 8'h00, -1, -1);
      chk_cnt("reset");
      check("reset_cnt4", 32'(bus4.instr_cnt), 32'd0);

      @(posedge clk); #1 rst = 1'b1;
      step();
      chk_out("idle", 4'b0000, 8'h00, -1, -1);
      step();

      // ADD R1,R2
      do_fetch("add", 8'h16);
      chk_out("add_dec", 4'b0000, F_LY, 1, 1);
      step();
      chk_out("add_ex1", 4'b0100, F_LZ, 2, 0);
      step(); exp_cnt++; chk_cnt("add");

      // RD R3
      do_fetch("rd", 8'h53);
      chk_out("rd_dec", 4'b0000, F_LAR, 4, 1);
      step();
      chk_out("rd_rd1", 4'b0000, F_LAR | F_IPC, -1, 2);
      step();
      chk_out("rd_rd2", 4'b1000, 8'h00, -1, 2);
      step(); exp_cnt++; chk_cnt("rd");

      // WR from R3
      do_fetch("wr", 8'h6C);
      chk_out("wr_dec", 4'b0000, F_LAR, 4, 1);
      step();
      chk_out("wr_wr1", 4'b0000, F_LAR | F_IPC, -1, 2);
      step();
      chk_out("wr_wr2", 4'b0000, F_WR, 3, -1);
      step(); exp_cnt++; chk_cnt("wr");

      // BRZ not taken
      bus.zero = 1'b0;
      do_fetch("brz0", 8'h80);
      chk_out("brz0_dec", 4'b0000, F_IPC, -1, -1);
      step(); exp_cnt++; chk_cnt("brz0");

      // BRZ taken
      bus.zero = 1'b1;
      do_fetch("brz1", 8'h80);
      chk_out("brz1_dec", 4'b0000, F_LAR, 4, 1);
      step();
      chk_out("brz1_br1", 4'b0000, F_LAR, -1, 2);
      step();
      chk_out("brz1_br2", 4'b0000, F_LPC, -1, 2);
      step(); exp_cnt++; chk_cnt("brz1");
      bus.zero = 1'b0;

      // NOT R2 -> R1
      do_fetch("not", 8'h49);
      chk_out("not_dec", 4'b0010, F_LZ, 2, 0);
      step(); exp_cnt++; chk_cnt("not");

      // NOP
      do_fetch("nop", 8'h00);
      chk_out("nop_dec", 4'b0000, 8'h00, -1, -1);
      step(); exp_cnt++; chk_cnt("nop");

      // Reset while in S_WR2
      do_fetch("rstwr", 8'h6C);
      step();
      step();
      chk_out("rstwr_wr2", 4'b0000, F_WR, 3, -1);
      #1 rst = 1'b0;
      #1;
      exp_cnt = 0;
      chk_out("rstwr_drop", 4'b0000, 8'h00, -1, -1);
      chk_cnt("rstwr_drop");
      step();
      step();
      @(posedge clk); #1 rst = 1'b1;
      step();
      chk_out("rstwr_idle", 4'b0000, 8'h00, -1, -1);
      step();

      // NOP then illegal opcode
      do_fetch("pre_ill", 8'h00);
      step(); exp_cnt++; chk_cnt("pre_ill");
      do_fetch("ill", 8'hF0);
      chk_out("ill_dec", 4'b0000, 8'h00, -1, -1);
      step();
      chk_out("ill_halt", 4'b0000, F_H, -1, -1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk_out("halt_hold", 4'b0000, F_H, -1, -1);
         chk_cnt("halt_hold");
      end

      // Counter saturation on the 4-bit instance running NOPs
      rst = 1'b0;
      step();
      @(posedge clk); #1 rst = 1'b1;
      for (int i = 1; i <= 61; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 43) check("sat_14", 32'(bus4.instr_cnt), 32'd14);
         if (i == 46) check("sat_15", 32'(bus4.instr_cnt), 32'd15);
         if (i == 61) check("sat_hold", 32'(bus4.instr_cnt), 32'd15);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
